// File: rtl/nn_mac_pipe_if.sv
// Operand/result stream bundle for nn_mac_pipe: valid/ready operand input
// plus valid/ready saturated result output.
interface nn_mac_pipe_if #(
  parameter int DIN0_WIDTH = 9,
  parameter int DIN1_WIDTH = 12,
  parameter int DOUT_WIDTH = 20
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  is_signed;
  logic                  first;
  logic                  last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  sat_flag;

  modport master (
    output in_valid, din0, din1, is_signed, first, last, out_ready,
    input  in_ready, out_valid, dout, sat_flag
  );

  modport slave (
    input  in_valid, din0, din1, is_signed, first, last, out_ready,
    output in_ready, out_valid, dout, sat_flag
  );
endinterface

// File: rtl/nn_mac_pipe.sv
// Pipelined signed/unsigned multiply-accumulate with vector framing, rounding
// right shift and output saturation; whole pipe stalls on output backpressure.
module nn_mac_pipe #(
  parameter int DIN0_WIDTH = 9,
  parameter int DIN1_WIDTH = 12,
  parameter int ACC_WIDTH  = 32,
  parameter int DOUT_WIDTH = 20,
  parameter int NUM_STAGE  = 3,
  parameter int SHIFT      = 0
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  nn_mac_pipe_if.slave  bus
);

  localparam int PW    = DIN0_WIDTH + DIN1_WIDTH;
  localparam int RW    = ACC_WIDTH + 2;
  localparam int LS    = NUM_STAGE - 1;
  localparam int SH_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [RW-1:0] RND_C = (SHIFT > 0) ? (RW'(1) << SH_M1) : RW'(0);
  localparam logic signed [RW-1:0] S_MAX = (RW'(1) << (DOUT_WIDTH - 1)) - RW'(1);
  localparam logic signed [RW-1:0] S_MIN = RW'(0) - (RW'(1) << (DOUT_WIDTH - 1));
  localparam logic signed [RW-1:0] U_MAX = (RW'(1) << DOUT_WIDTH) - RW'(1);

  logic                  advance;

  logic [PW-1:0]         a_x, b_x, prod_w;
  logic [ACC_WIDTH-1:0]  prod_d;

  logic [ACC_WIDTH-1:0]  st_prod_q [NUM_STAGE];
  logic [NUM_STAGE-1:0]  st_vld_q, st_first_q, st_last_q, st_sgn_q;

  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic                  res_vld_q, res_sgn_q;
  logic [ACC_WIDTH-1:0]  res_acc_q;

  logic signed [RW-1:0]  ext_s, rnd_s, shf_s;
  logic [DOUT_WIDTH-1:0] dout_d, dout_q;
  logic                  sat_d, sat_q, out_valid_q;

  assign advance       = ~out_valid_q | bus.out_ready;
  assign bus.in_ready  = advance & ~ap_rst;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.sat_flag  = sat_q;

  // A PW-bit product is exact in both modes, so extending operands to PW
  // bits and keeping the low PW bits of the product is sufficient.
  always_comb begin
    if (bus.is_signed) begin
      a_x = PW'($signed(bus.din0));
      b_x = PW'($signed(bus.din1));
    end else begin
      a_x = PW'(bus.din0);
      b_x = PW'(bus.din1);
    end
    prod_w = a_x * b_x;
    if (bus.is_signed) prod_d = ACC_WIDTH'($signed(prod_w));
    else               prod_d = ACC_WIDTH'(prod_w);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      st_vld_q   <= '0;
      st_first_q <= '0;
      st_last_q  <= '0;
      st_sgn_q   <= '0;
      for (int i = 0; i < NUM_STAGE; i++) st_prod_q[i] <= '0;
    end else if (advance) begin
      st_vld_q[0]   <= bus.in_valid;
      st_first_q[0] <= bus.first;
      st_last_q[0]  <= bus.last;
      st_sgn_q[0]   <= bus.is_signed;
      st_prod_q[0]  <= prod_d;
      for (int i = 1; i < NUM_STAGE; i++) begin
        st_vld_q[i]   <= st_vld_q[i-1];
        st_first_q[i] <= st_first_q[i-1];
        st_last_q[i]  <= st_last_q[i-1];
        st_sgn_q[i]   <= st_sgn_q[i-1];
        st_prod_q[i]  <= st_prod_q[i-1];
      end
    end
  end

  assign acc_d = (st_first_q[LS] ? '0 : acc_q) + st_prod_q[LS];

  // Clearing on last lets a following beat without first start from zero.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_q     <= '0;
      res_vld_q <= 1'b0;
      res_sgn_q <= 1'b0;
      res_acc_q <= '0;
    end else if (advance) begin
      res_vld_q <= st_vld_q[LS] & st_last_q[LS];
      if (st_vld_q[LS]) begin
        acc_q     <= st_last_q[LS] ? '0 : acc_d;
        res_acc_q <= acc_d;
        res_sgn_q <= st_sgn_q[LS];
      end
    end
  end

  // Two guard bits keep the rounding add and the saturation compare exact.
  always_comb begin
    if (res_sgn_q) ext_s = RW'($signed(res_acc_q));
    else           ext_s = RW'(res_acc_q);
    rnd_s  = ext_s + RND_C;
    shf_s  = rnd_s >>> SHIFT;
    dout_d = shf_s[DOUT_WIDTH-1:0];
    sat_d  = 1'b0;
    if (res_sgn_q) begin
      if (shf_s > S_MAX) begin
        dout_d = S_MAX[DOUT_WIDTH-1:0];
        sat_d  = 1'b1;
      end else if (shf_s < S_MIN) begin
        dout_d = S_MIN[DOUT_WIDTH-1:0];
        sat_d  = 1'b1;
      end
    end else if (shf_s > U_MAX) begin
      dout_d = U_MAX[DOUT_WIDTH-1:0];
      sat_d  = 1'b1;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      sat_q       <= 1'b0;
    end else if (advance) begin
      out_valid_q <= res_vld_q;
      if (res_vld_q) begin
        dout_q <= dout_d;
        sat_q  <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_nn_mac_pipe.sv
// Bench for nn_mac_pipe: two instances (SHIFT=0 and SHIFT=4) share one
// stimulus stream; results are scored against an integer arithmetic model.
module tb_nn_mac_pipe;

  logic ap_clk;
  logic ap_rst;

  nn_mac_pipe_if #(.DIN0_WIDTH(9), .DIN1_WIDTH(12), .DOUT_WIDTH(20)) b0 ();
  nn_mac_pipe_if #(.DIN0_WIDTH(9), .DIN1_WIDTH(12), .DOUT_WIDTH(20)) b4 ();

  assign b4.in_valid  = b0.in_valid;
  assign b4.din0      = b0.din0;
  assign b4.din1      = b0.din1;
  assign b4.is_signed = b0.is_signed;
  assign b4.first     = b0.first;
  assign b4.last      = b0.last;
  assign b4.out_ready = b0.out_ready;

  nn_mac_pipe #(.SHIFT(0)) dut0 (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(b0.slave));
  nn_mac_pipe #(.SHIFT(4)) dut4 (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(b4.slave));

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  int          n_assert = 0;
  int          n_fail   = 0;
  bit          rand_bp  = 0;
  longint      run_sum  = 0;
  logic [20:0] exp0[$], exp4[$], obs0[$], obs4[$];

  always @(negedge ap_clk) begin
    if (b0.out_valid && b0.out_ready) obs0.push_back({b0.sat_flag, b0.dout});
    if (b4.out_valid && b4.out_ready) obs4.push_back({b4.sat_flag, b4.dout});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result of a whole vector: wrap sum to 32 bits, round-shift, clamp.
  function automatic logic [20:0] model(input longint sum, input bit sgn, input int sh);
    longint w, r, lo, hi;
    bit     sat;
    if (sgn) w = longint'($signed(sum[31:0]));
    else     w = longint'(sum[31:0]);
    if (sh > 0) r = (w + (64'sd1 <<< (sh - 1))) >>> sh;
    else        r = w;
    if (sgn) begin lo = -(64'sd1 <<< 19); hi = (64'sd1 <<< 19) - 1; end
    else     begin lo = 0;                hi = (64'sd1 <<< 20) - 1; end
    sat = 1'b0;
    if (r > hi)      begin r = hi; sat = 1'b1; end
    else if (r < lo) begin r = lo; sat = 1'b1; end
    return {sat, r[19:0]};
  endfunction

  task automatic beat(input int a, input int b, input bit sgn, input bit f, input bit l);
    bit rdy;
    int n;
    b0.din0      = a[8:0];
    b0.din1      = b[11:0];
    b0.is_signed = sgn;
    b0.first     = f;
    b0.last      = l;
    b0.in_valid  = 1'b1;
    n = 0;
    do begin
      if (rand_bp) b0.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge ap_clk);
      rdy = b0.in_ready;
      @(posedge ap_clk);
      #1;
      n++;
    end while (!rdy && n < 200);
    b0.in_valid = 1'b0;
    chk("beat_accept", 64'(rdy), 64'(1'b1));
    if (f) run_sum = 0;
    run_sum += longint'(a) * longint'(b);
    if (l) begin
      exp0.push_back(model(run_sum, sgn, 0));
      exp4.push_back(model(run_sum, sgn, 4));
      run_sum = 0;
    end
  endtask

  task automatic drain();
    rand_bp      = 0;
    b0.out_ready = 1'b1;
    repeat (12) @(posedge ap_clk);
    #1;
  endtask

  task automatic compare(input string tag);
    chk({tag, "_count0"}, 64'(obs0.size()), 64'(exp0.size()));
    chk({tag, "_count4"}, 64'(obs4.size()), 64'(exp4.size()));
    for (int i = 0; i < exp0.size() && i < obs0.size(); i++)
      chk($sformatf("%s_s0_%0d", tag, i), 64'(obs0[i]), 64'(exp0[i]));
    for (int i = 0; i < exp4.size() && i < obs4.size(); i++)
      chk($sformatf("%s_s4_%0d", tag, i), 64'(obs4[i]), 64'(exp4[i]));
    obs0.delete(); exp0.delete(); obs4.delete(); exp4.delete();
  endtask

  initial begin
    int n, len, a, b;
    bit sgn;

    b0.in_valid  = 1'b0;
    b0.din0      = '0;
    b0.din1      = '0;
    b0.is_signed = 1'b0;
    b0.first     = 1'b0;
    b0.last      = 1'b0;
    b0.out_ready = 1'b1;
    ap_rst       = 1'b1;

    // Reset state
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_out_valid", 64'(b0.out_valid), 64'(1'b0));
    chk("rst_dout",      64'(b0.dout),      64'(20'd0));
    chk("rst_sat",       64'(b0.sat_flag),  64'(1'b0));
    chk("rst_in_ready",  64'(b0.in_ready),  64'(1'b0));
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    chk("post_rst_in_ready", 64'(b0.in_ready), 64'(1'b1));

    // Unsigned single beats, latency measurement
    beat(300, 1000, 0, 1, 1);
    n = 0;
    while (!b0.out_valid && n < 20) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(4));
    beat(511, 4095, 0, 1, 1);
    drain();
    compare("unsigned");

    // Reset in the middle of a vector
    beat(3, 3, 0, 1, 0);
    beat(7, 7, 0, 0, 0);
    #2;
    ap_rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(b0.out_valid), 64'(1'b0));
    chk("midrst_dout",      64'(b0.dout),      64'(20'd0));
    chk("midrst_sat",       64'(b0.sat_flag),  64'(1'b0));
    chk("midrst_in_ready",  64'(b0.in_ready),  64'(1'b0));
    run_sum = 0;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    beat(3, 4, 0, 1, 1);
    drain();
    compare("after_reset");

    // Signed vector, signed saturation, rounding shift
    beat(-3, 100, 1, 1, 0);
    beat(5, -20, 1, 0, 0);
    beat(7, 7, 1, 0, 1);
    for (int k = 0; k < 4; k++) beat(-256, -2048, 1, k == 0, k == 3);
    beat(5, 5, 0, 1, 1);
    drain();
    compare("signed");

    // Backpressure: result must hold while the consumer stalls
    b0.out_ready = 1'b0;
    beat(2, 3, 0, 1, 1);
    beat(4, 5, 0, 1, 1);
    n = 0;
    while (!b0.out_valid && n < 20) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    chk("bp_out_valid", 64'(b0.out_valid), 64'(1'b1));
    for (int k = 0; k < 6; k++) begin
      @(negedge ap_clk);
      chk("bp_in_ready",  64'(b0.in_ready),  64'(1'b0));
      chk("bp_out_valid", 64'(b0.out_valid), 64'(1'b1));
      chk("bp_dout_hold", 64'(b0.dout),      64'(exp0[0][19:0]));
    end
    @(posedge ap_clk);
    #1;
    drain();
    compare("backpressure");

    // Missing first after a completed vector
    beat(2, 3, 0, 0, 1);
    drain();
    compare("no_first");

    // Random vectors with random consumer backpressure and input gaps
    rand_bp = 1;
    for (int v = 0; v < 40; v++) begin
      len = int'($urandom_range(1, 4));
      sgn = $urandom_range(0, 1) != 0;
      for (int k = 0; k < len; k++) begin
        if (sgn) begin
          a = int'($urandom_range(0, 511)) - 256;
          b = int'($urandom_range(0, 4095)) - 2048;
        end else begin
          a = int'($urandom_range(0, 511));
          b = int'($urandom_range(0, 4095));
        end
        beat(a, b, sgn, k == 0, k == len - 1);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge ap_clk);
          #1;
        end
      end
    end
    drain();
    compare("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
